// File: rtl/lock_pkg.sv
// Shared types and display glyphs for the combination lock.
// Glyphs are active-low: bit7 = dp, bits6:0 = g..a.
package lock_pkg;

  typedef enum logic [2:0] {
    StLocked,
    StCheck,
    StOpen,
    StProgram,
    StLockout
  } state_e;

  localparam logic [7:0] GlyphBlank = 8'hFF;
  localparam logic [7:0] GlyphDash  = 8'hBF;
  localparam logic [7:0] GlyphO     = 8'hC0;
  localparam logic [7:0] GlyphP     = 8'h8C;
  localparam logic [7:0] GlyphE     = 8'h86;
  localparam logic [7:0] GlyphN     = 8'hC8;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] v);
    logic [7:0] seg;
    case (v)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_scan_mux.sv
// Four-digit seven-segment scanner: rotates one active-low anode every
// REFRESH_CYCLES clocks and drives the matching glyph.
module seg_scan_mux #(
  parameter int unsigned REFRESH_CYCLES = 250
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_glyphs,
  output logic [7:0]  o_seg_data,
  output logic [3:0]  o_seg_enable
);

  localparam int unsigned RefW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  logic [RefW-1:0] r_refresh;
  logic [1:0]      r_idx;
  logic            r_active;

  // r_active keeps the display dark for the reset cycle itself.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_refresh <= '0;
      r_idx     <= '0;
      r_active  <= 1'b0;
    end else begin
      r_active <= 1'b1;
      if (r_active) begin
        if (r_refresh == RefW'(REFRESH_CYCLES - 1)) begin
          r_refresh <= '0;
          r_idx     <= r_idx + 2'd1;
        end else begin
          r_refresh <= r_refresh + RefW'(1);
        end
      end
    end
  end

  always_comb begin
    o_seg_enable = 4'hF;
    o_seg_data   = 8'hFF;
    if (r_active) begin
      o_seg_enable = ~(4'b0001 << r_idx);
      o_seg_data   = i_glyphs[{r_idx, 3'b000} +: 8];
    end
  end

endmodule

// File: rtl/combination_lock_param.sv
// Parametrised combination lock with reprogrammable code, failed-attempt
// lockout and a multiplexed four-digit status display.
module combination_lock_param
  import lock_pkg::*;
#(
  parameter int unsigned DIGIT_W        = 4,
  parameter int unsigned CODE_LEN       = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 1000,
  parameter int unsigned REFRESH_CYCLES = 250
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DIGIT_W-1:0] x,
  input  logic               enter,
  input  logic               lock,
  input  logic               set_code,
  output logic               door_open,
  output logic               alarm,
  output logic [3:0]         tries_left,
  output logic [7:0]         seven_segment_data,
  output logic [3:0]         seven_segment_enable
);

  localparam int unsigned CodeW  = CODE_LEN * DIGIT_W;
  localparam int unsigned CntW   = $clog2(CODE_LEN + 1);
  localparam int unsigned FailW  = $clog2(MAX_TRIES + 1);
  localparam int unsigned TimerW = (LOCKOUT_CYCLES > 0) ? $clog2(LOCKOUT_CYCLES + 1) : 1;

  state_e              r_state, w_state_next;
  logic [CodeW-1:0]    r_code, w_code_next;
  logic [CodeW-1:0]    r_buf, w_buf_next;
  logic [CntW-1:0]     r_count, w_count_next;
  logic [FailW-1:0]    r_fails, w_fails_next;
  logic [TimerW-1:0]   r_timer, w_timer_next;

  logic [CodeW-1:0]          w_shift;
  logic                      w_last;
  logic [CodeW+4*DIGIT_W-1:0] w_buf_ext;
  logic [31:0]               w_glyphs;

  assign w_shift   = (r_buf << DIGIT_W) | CodeW'(x);
  assign w_last    = (r_count == CntW'(CODE_LEN - 1));
  assign w_buf_ext = {{(4 * DIGIT_W){1'b0}}, r_buf};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StLocked;
      r_code  <= DEFAULT_CODE;
      r_buf   <= '0;
      r_count <= '0;
      r_fails <= '0;
      r_timer <= '0;
    end else begin
      r_state <= w_state_next;
      r_code  <= w_code_next;
      r_buf   <= w_buf_next;
      r_count <= w_count_next;
      r_fails <= w_fails_next;
      r_timer <= w_timer_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_code_next  = r_code;
    w_buf_next   = r_buf;
    w_count_next = r_count;
    w_fails_next = r_fails;
    w_timer_next = r_timer;
    case (r_state)
      StLocked, StProgram: begin
        // lock outranks enter; a digit in the same cycle is dropped.
        if (lock) begin
          w_buf_next   = '0;
          w_count_next = '0;
          w_state_next = StLocked;
        end else if (enter) begin
          w_buf_next = w_shift;
          if (w_last) begin
            w_count_next = '0;
            if (r_state == StLocked) begin
              w_state_next = StCheck;
            end else begin
              w_code_next  = w_shift;
              w_state_next = StOpen;
            end
          end else begin
            w_count_next = r_count + CntW'(1);
          end
        end
      end
      StCheck: begin
        w_buf_next = '0;
        if (r_buf == r_code) begin
          w_fails_next = '0;
          w_state_next = StOpen;
        end else if (r_fails >= FailW'(MAX_TRIES - 1)) begin
          w_fails_next = FailW'(MAX_TRIES);
          w_timer_next = TimerW'(LOCKOUT_CYCLES);
          w_state_next = StLockout;
        end else begin
          w_fails_next = r_fails + FailW'(1);
          w_state_next = StLocked;
        end
      end
      StOpen: begin
        if (lock) begin
          w_buf_next   = '0;
          w_count_next = '0;
          w_state_next = StLocked;
        end else if (set_code) begin
          w_state_next = StProgram;
        end
      end
      StLockout: begin
        if (r_timer <= TimerW'(1)) begin
          w_fails_next = '0;
          w_timer_next = '0;
          w_state_next = StLocked;
        end else begin
          w_timer_next = r_timer - TimerW'(1);
        end
      end
      default: w_state_next = StLocked;
    endcase
  end

  assign door_open  = (r_state == StOpen) || (r_state == StProgram);
  assign alarm      = (r_state == StLockout);
  assign tries_left = 4'(MAX_TRIES - int'(r_fails));

  // Slot 0 is the rightmost digit and shows the most recent entry.
  always_comb begin
    w_glyphs = {4{GlyphBlank}};
    unique case (r_state)
      StOpen:    w_glyphs = {GlyphO, GlyphP, GlyphE, GlyphN};
      StLockout: w_glyphs = {4{GlyphDash}};
      default: begin
        for (int i = 0; i < 4; i++) begin
          if (i < int'(r_count)) begin
            w_glyphs[i*8 +: 8] = hex_to_seg(4'(w_buf_ext[i*DIGIT_W +: DIGIT_W]));
          end
          if (r_state == StProgram) begin
            w_glyphs[i*8+7] = 1'b0;
          end
        end
      end
    endcase
  end

  seg_scan_mux #(
    .REFRESH_CYCLES(REFRESH_CYCLES)
  ) u_scan (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_glyphs    (w_glyphs),
    .o_seg_data  (seven_segment_data),
    .o_seg_enable(seven_segment_enable)
  );

endmodule
